// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl
// Mux-D scan register stage with its own capture/shift/update sequencer.
// The serial path enters at the MSB and leaves at the LSB (SO = chain[0]).
// The chain stores data non-inverted. PO is a shadow register that changes
// only on the UPDATE edge, or when reset clears it.
module scan_chain_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             CAP_EN,
    input  logic             SI,
    input  logic [WIDTH-1:0] PI,
    output logic             SO,
    output logic             SE,
    output logic [WIDTH-1:0] PO,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_UPDATE  = 2'd3
    } state_t;

    // Counter value on the edge that performs the final (WIDTH-th) shift.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q;
    logic [WIDTH-1:0]   chain_q;
    logic [WIDTH-1:0]   po_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;
    logic [WIDTH-1:0]   shift_d;

    // Next chain value for one shift: SI enters at the MSB and the LSB drops out.
    always_comb begin
        shift_d = {SI, chain_q[WIDTH-1:1]};
    end

    // Sequencer: holds the state, chain, shift counter, shadow PO and DONE pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            chain_q <= '0;
            po_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // DONE is high only in the cycle that follows the UPDATE edge.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        if (CAP_EN) begin
                            state_q <= ST_CAPTURE;
                        end else begin
                            state_q <= ST_SHIFT;
                            cnt_q   <= '0;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    chain_q <= PI;
                    cnt_q   <= '0;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    chain_q <= shift_d;
                    if (cnt_q == CNT_LAST) begin
                        // Final shift: clear the counter so it never passes WIDTH-1.
                        cnt_q   <= '0;
                        state_q <= ST_UPDATE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_UPDATE: begin
                    po_q    <= chain_q;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Outputs are either registers or a plain decode of the state register.
    always_comb begin
        SO   = chain_q[0];
        SE   = (state_q == ST_SHIFT);
        BUSY = (state_q != ST_IDLE);
        PO   = po_q;
        DONE = done_q;
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl (WIDTH = 8).
// The bench uses directed vector tables and hand-written corner sequences.
// It also runs randomized operations against a behavioural model. That model
// states the data rules directly: after WIDTH shifts the chain holds exactly
// the shifted-in SI bits, and the SO stream is the starting chain, LSB first.
module tb_scan_chain_ctrl;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         START = 1'b0;
    logic         CAP_EN = 1'b0;
    logic         SI = 1'b0;
    logic [W-1:0] PI = '0;
    logic         SO;
    logic         SE;
    logic [W-1:0] PO;
    logic         BUSY;
    logic         DONE;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done_cyc = 0;

    // Model state: the value PO should hold and the chain contents left behind.
    logic [W-1:0] mdl_po = '0;
    logic [W-1:0] mdl_chain = '0;

    scan_chain_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .CAP_EN(CAP_EN), .SI(SI), .PI(PI),
        .SO(SO), .SE(SE), .PO(PO), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Count rising edges so that DONE spacing can be measured.
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic         cap;
        logic [W-1:0] pi;
        logic [W-1:0] si;
        logic [W-1:0] exp_so;
        logic [W-1:0] exp_po;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One idle cycle with noise on the inputs; nothing is allowed to move.
    task automatic idle_tick();
        START = 1'b0;
        SI = 1'($urandom);
        PI = W'($urandom);
        step();
        chk("idle_done", DONE, 1'b0);
        chk("idle_busy", BUSY, 1'b0);
        chk("idle_se", SE, 1'b0);
        chk("idle_po", PO, mdl_po);
        chk("idle_so", SO, mdl_chain[0]);
    endtask

    // A full operation begins at the current time, which is 1 ns after an edge.
    // inj >= 0 raises a stray START (with the opposite CAP_EN) in that shift cycle.
    task automatic run_op(input logic cap, input logic [W-1:0] pi, input logic [W-1:0] si,
                          input logic [W-1:0] exp_so, input logic [W-1:0] exp_po, input int inj);
        START = 1'b1;
        CAP_EN = cap;
        PI = pi;
        SI = 1'($urandom);
        step();                                   // e0
        START = 1'b0;
        CAP_EN = 1'($urandom);
        if (cap) begin
            chk("cap_busy", BUSY, 1'b1);
            chk("cap_se", SE, 1'b0);
            chk("cap_done", DONE, 1'b0);
            SI = 1'($urandom);
            step();                               // capture edge
        end
        PI = W'($urandom);
        for (int i = 0; i < W; i++) begin
            chk("sh_se", SE, 1'b1);
            chk("sh_busy", BUSY, 1'b1);
            chk("sh_done", DONE, 1'b0);
            chk("sh_po_hold", PO, mdl_po);
            chk($sformatf("sh_so[%0d]", i), SO, exp_so[i]);
            SI = si[i];
            if (i == inj) begin
                START = 1'b1;
                CAP_EN = ~cap;
            end else begin
                START = 1'b0;
            end
            step();
        end
        START = 1'b0;
        SI = 1'($urandom);
        chk("upd_se", SE, 1'b0);
        chk("upd_busy", BUSY, 1'b1);
        chk("upd_done", DONE, 1'b0);
        chk("upd_po_hold", PO, mdl_po);
        step();                                   // update edge
        chk("done_pulse", DONE, 1'b1);
        chk("done_busy", BUSY, 1'b0);
        chk("done_po", PO, exp_po);
        last_done_cyc = cyc;
        mdl_po = exp_po;
        mdl_chain = exp_po;
    endtask

    vec_t vecs[6];
    logic         r_cap;
    logic [W-1:0] r_pi;
    logic [W-1:0] r_si;
    logic [W-1:0] r_so;
    int           t0;

    initial begin
        vecs[0] = '{cap: 1'b1, pi: 8'hA5, si: 8'h00, exp_so: 8'hA5, exp_po: 8'h00};
        vecs[1] = '{cap: 1'b0, pi: 8'hFF, si: 8'hD3, exp_so: 8'h00, exp_po: 8'hD3};
        vecs[2] = '{cap: 1'b1, pi: 8'h3C, si: 8'hFF, exp_so: 8'h3C, exp_po: 8'hFF};
        vecs[3] = '{cap: 1'b0, pi: 8'h00, si: 8'h3C, exp_so: 8'hFF, exp_po: 8'h3C};
        vecs[4] = '{cap: 1'b1, pi: 8'h81, si: 8'h7E, exp_so: 8'h81, exp_po: 8'h7E};
        vecs[5] = '{cap: 1'b0, pi: 8'h55, si: 8'h01, exp_so: 8'h7E, exp_po: 8'h01};

        // Asynchronous reset with no clock edge yet.
        #2 RST = 1'b1;
        #1;
        chk("rst_po", PO, 8'h00);
        chk("rst_so", SO, 1'b0);
        chk("rst_se", SE, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        idle_tick();

        // Directed vectors, each followed by an idle cycle so DONE must drop.
        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].cap, vecs[v].pi, vecs[v].si, vecs[v].exp_so, vecs[v].exp_po, -1);
            idle_tick();
        end

        // A START during SHIFT is ignored: one DONE, and nothing queued.
        run_op(1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 3);
        repeat (W + 3) idle_tick();

        // Back-to-back: START raised in the DONE cycle.
        run_op(1'b0, 8'h00, 8'h96, 8'hC3, 8'h96, -1);
        t0 = last_done_cyc;
        run_op(1'b0, 8'h00, 8'h3C, 8'h96, 8'h3C, -1);
        chk("b2b_spacing", 32'(last_done_cyc - t0), 32'(W + 2));
        idle_tick();

        // Abort: reset in the 4th SHIFT cycle while PO holds 0x3C.
        chk("abort_pre_po", PO, 8'h3C);
        START = 1'b1;
        CAP_EN = 1'b0;
        step();
        START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            SI = 1'b1;
            step();
        end
        chk("abort_in_shift", SE, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("abort_po", PO, 8'h00);
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_se", SE, 1'b0);
        chk("abort_so", SO, 1'b0);
        chk("abort_done", DONE, 1'b0);
        #1 RST = 1'b0;
        mdl_po = '0;
        mdl_chain = '0;
        repeat (W + 3) idle_tick();
        run_op(1'b1, 8'hE7, 8'h18, 8'hE7, 8'h18, -1);
        idle_tick();

        // Randomized operations against the behavioural model.
        for (int r = 0; r < 24; r++) begin
            r_cap = 1'($urandom);
            r_pi = W'($urandom);
            r_si = W'($urandom);
            r_so = r_cap ? r_pi : mdl_chain;
            repeat ($urandom_range(0, 2)) idle_tick();
            run_op(r_cap, r_pi, r_si, r_so, r_si, -1);
        end
        idle_tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
